// File: rtl/stage_stride_unpermutation_pkg.sv
// Shared types and helpers for the stride de-permutation stage.
// Holds the default frame geometry, the FSM state encodings, and the
// output-to-input index mapping. The RTL and the reference model both use
// that mapping.
package ntt_perm_pkg;

    localparam int unsigned DEF_N       = 1024;
    localparam int unsigned DEF_IPC     = 64;
    localparam int unsigned FRAME_BEATS = DEF_N / DEF_IPC;
    localparam int unsigned BEAT_CNT_W  = $clog2(FRAME_BEATS);

    typedef enum logic {W_IDLE, W_FILL}  wr_state_t;
    typedef enum logic {R_IDLE, R_DRAIN} rd_state_t;

    // Output index j takes input index (j mod Q)*STRIDE + (j div Q), Q = N/STRIDE.
    // With power-of-two sizes, div/mod are the high/low bit fields of j.
    function automatic int unsigned unperm_src_index(input int unsigned j,
                                                     input int unsigned log2n,
                                                     input int unsigned log2s);
        int unsigned log2q;
        int unsigned jm;
        log2q = log2n - log2s;
        jm    = j & ((32'd1 << log2n) - 32'd1);
        return ((jm & ((32'd1 << log2q) - 32'd1)) << log2s) | (jm >> log2q);
    endfunction

endpackage

// File: rtl/stage_stride_unpermutation_if.sv
// Stream bundle for the de-permutation stage.
//   inData[]  : input lanes, one element per lane per beat
//   in_start  : pulse with input beat 0
//   outData[] : output lanes (registered in the DUT)
//   out_start : pulse with output beat 0
// master = stream source/sink (bench side), slave = the de-permutation block.
interface stage_stride_unpermutation_if #(
    parameter int unsigned DATA_WIDTH_PER_INPUT = 28,
    parameter int unsigned INPUT_PER_CYCLE      = 64
);
    logic [DATA_WIDTH_PER_INPUT-1:0] inData  [INPUT_PER_CYCLE];
    logic                            in_start;
    logic [DATA_WIDTH_PER_INPUT-1:0] outData [INPUT_PER_CYCLE];
    logic                            out_start;

    modport master (output inData, output in_start, input outData, input out_start);
    modport slave  (input inData, input in_start, output outData, output out_start);
endinterface

// File: rtl/stage_stride_unpermutation_bank.sv
// perm_frame_bank: one frame of N elements held in registers.
//   clk       : clock
//   we_i      : write one beat this cycle
//   wr_beat_i : beat index written (elements wr_beat*IPC .. +IPC-1)
//   wr_data_i : beat data, one element per lane
//   rd_beat_i : output beat being gathered
//   rd_data_o : combinational gather, lane l = element unperm_src_index(rd_beat*IPC+l)
module perm_frame_bank
    import ntt_perm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH_PER_INPUT = 28,
    parameter int unsigned INPUT_PER_CYCLE      = 64,
    parameter int unsigned N                    = 1024,
    parameter int unsigned STRIDE               = 2
) (
    input  logic                            clk,
    input  logic                            we_i,
    input  logic [$clog2(N/INPUT_PER_CYCLE)-1:0] wr_beat_i,
    input  logic [DATA_WIDTH_PER_INPUT-1:0] wr_data_i [INPUT_PER_CYCLE],
    input  logic [$clog2(N/INPUT_PER_CYCLE)-1:0] rd_beat_i,
    output logic [DATA_WIDTH_PER_INPUT-1:0] rd_data_o [INPUT_PER_CYCLE]
);
    localparam int unsigned AW = $clog2(N);
    localparam int unsigned LW = $clog2(INPUT_PER_CYCLE);
    localparam int unsigned SW = $clog2(STRIDE);

    logic [DATA_WIDTH_PER_INPUT-1:0] mem_q [N];

    // Contents are never reset: a frame is always fully written before it is read.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int unsigned l = 0; l < INPUT_PER_CYCLE; l++) begin
                mem_q[{wr_beat_i, LW'(l)}] <= wr_data_i[l];
            end
        end
    end

    for (genvar l = 0; l < INPUT_PER_CYCLE; l++) begin : g_lane
        logic [AW-1:0] src;
        assign src = AW'(unperm_src_index((32'(rd_beat_i) << LW) | 32'(l), AW, SW));
        assign rd_data_o[l] = mem_q[src];
    end

endmodule

// File: rtl/stage_stride_unpermutation.sv
// stage_stride_unpermutation: restores element order after a stride permutation.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : stream bundle (slave) - inData/in_start in, outData/out_start out
// A frame arrives as N/INPUT_PER_CYCLE contiguous beats after in_start. It is
// stored in one of two ping-pong banks and drained reordered one beat per
// cycle. out_start comes B+1 cycles after in_start.
module stage_stride_unpermutation
    import ntt_perm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH_PER_INPUT = 28,
    parameter int unsigned INPUT_PER_CYCLE      = 64,
    parameter int unsigned N                    = DEF_N,
    parameter int unsigned STRIDE               = 2
) (
    input logic                          clk,
    input logic                          rst,
    stage_stride_unpermutation_if.slave  bus
);
    localparam int unsigned   BEATS     = N / INPUT_PER_CYCLE;
    localparam int unsigned   CW        = $clog2(BEATS);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    wr_state_t     wr_state_q;
    logic [CW-1:0] wr_cnt_q;
    logic          wr_ptr_q;
    rd_state_t     rd_state_q;
    logic [CW-1:0] rd_cnt_q;
    logic          rd_ptr_q;
    logic [1:0]    full_q;

    logic          wr_en, wr_done, rd_en, rd_done;
    logic [CW-1:0] wr_beat, rd_beat;

    logic [DATA_WIDTH_PER_INPUT-1:0] in_data    [INPUT_PER_CYCLE];
    logic [DATA_WIDTH_PER_INPUT-1:0] rd0        [INPUT_PER_CYCLE];
    logic [DATA_WIDTH_PER_INPUT-1:0] rd1        [INPUT_PER_CYCLE];
    logic [DATA_WIDTH_PER_INPUT-1:0] out_data_d [INPUT_PER_CYCLE];
    logic [DATA_WIDTH_PER_INPUT-1:0] out_data_q [INPUT_PER_CYCLE];
    logic                            out_start_q;

    assign in_data = bus.inData;

    // Beat 0 is written from IDLE in the in_start cycle itself.
    assign wr_en   = !rst && ((wr_state_q == W_IDLE && bus.in_start) || wr_state_q == W_FILL);
    assign wr_beat = (wr_state_q == W_FILL) ? wr_cnt_q : '0;
    assign wr_done = (wr_state_q == W_FILL) && (wr_cnt_q == LAST_BEAT);

    // Likewise, output beat 0 is read from IDLE as soon as the bank shows full.
    assign rd_en   = (rd_state_q == R_IDLE && full_q[rd_ptr_q]) || rd_state_q == R_DRAIN;
    assign rd_beat = (rd_state_q == R_DRAIN) ? rd_cnt_q : '0;
    assign rd_done = (rd_state_q == R_DRAIN) && (rd_cnt_q == LAST_BEAT);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_q <= W_IDLE;
            wr_cnt_q   <= '0;
            wr_ptr_q   <= 1'b0;
        end else begin
            case (wr_state_q)
                W_IDLE: if (bus.in_start) begin
                    wr_state_q <= W_FILL;
                    wr_cnt_q   <= CW'(1);
                end
                W_FILL: begin
                    wr_cnt_q <= wr_cnt_q + 1'b1;
                    if (wr_done) begin
                        wr_state_q <= W_IDLE;
                        wr_cnt_q   <= '0;
                        wr_ptr_q   <= ~wr_ptr_q;
                    end
                end
                default: wr_state_q <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_q <= R_IDLE;
            rd_cnt_q   <= '0;
            rd_ptr_q   <= 1'b0;
        end else begin
            case (rd_state_q)
                R_IDLE: if (full_q[rd_ptr_q]) begin
                    rd_state_q <= R_DRAIN;
                    rd_cnt_q   <= CW'(1);
                end
                R_DRAIN: begin
                    rd_cnt_q <= rd_cnt_q + 1'b1;
                    if (rd_done) begin
                        rd_ptr_q <= ~rd_ptr_q;
                        rd_cnt_q <= '0;
                        if (!full_q[~rd_ptr_q]) rd_state_q <= R_IDLE;
                    end
                end
                default: rd_state_q <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= '0;
        end else begin
            if (rd_done) full_q[rd_ptr_q] <= 1'b0;
            if (wr_done) full_q[wr_ptr_q] <= 1'b1;
        end
    end

    perm_frame_bank #(
        .DATA_WIDTH_PER_INPUT(DATA_WIDTH_PER_INPUT), .INPUT_PER_CYCLE(INPUT_PER_CYCLE),
        .N(N), .STRIDE(STRIDE)
    ) u_bank0 (
        .clk(clk), .we_i(wr_en && !wr_ptr_q), .wr_beat_i(wr_beat), .wr_data_i(in_data),
        .rd_beat_i(rd_beat), .rd_data_o(rd0)
    );

    perm_frame_bank #(
        .DATA_WIDTH_PER_INPUT(DATA_WIDTH_PER_INPUT), .INPUT_PER_CYCLE(INPUT_PER_CYCLE),
        .N(N), .STRIDE(STRIDE)
    ) u_bank1 (
        .clk(clk), .we_i(wr_en && wr_ptr_q), .wr_beat_i(wr_beat), .wr_data_i(in_data),
        .rd_beat_i(rd_beat), .rd_data_o(rd1)
    );

    always_comb begin
        for (int unsigned l = 0; l < INPUT_PER_CYCLE; l++) begin
            out_data_d[l] = '0;
            if (rd_en) out_data_d[l] = rd_ptr_q ? rd1[l] : rd0[l];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_start_q <= 1'b0;
            for (int unsigned l = 0; l < INPUT_PER_CYCLE; l++) out_data_q[l] <= '0;
        end else begin
            out_start_q <= rd_en && (rd_beat == '0);
            for (int unsigned l = 0; l < INPUT_PER_CYCLE; l++) out_data_q[l] <= out_data_d[l];
        end
    end

    assign bus.outData   = out_data_q;
    assign bus.out_start = out_start_q;

endmodule

// File: tb/tb_stage_stride_unpermutation.sv
// Directed bench for stage_stride_unpermutation: three instances (STRIDE 2, 16, 1)
// share one input stream, and every output cycle is compared against expectations.
module tb_stage_stride_unpermutation;
    import ntt_perm_pkg::*;

    localparam int DW  = 28;
    localparam int IPC = 64;
    localparam int B   = FRAME_BEATS;
    localparam int W   = 72;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          in_start;
    logic [DW-1:0] din [IPC];

    int cyc = 0;
    int org = 1 << 30;
    always @(posedge clk) cyc <= cyc + 1;

    stage_stride_unpermutation_if #(.DATA_WIDTH_PER_INPUT(DW), .INPUT_PER_CYCLE(IPC)) if2 ();
    stage_stride_unpermutation_if #(.DATA_WIDTH_PER_INPUT(DW), .INPUT_PER_CYCLE(IPC)) if16 ();
    stage_stride_unpermutation_if #(.DATA_WIDTH_PER_INPUT(DW), .INPUT_PER_CYCLE(IPC)) if1 ();

    assign if2.inData  = din;  assign if2.in_start  = in_start;
    assign if16.inData = din;  assign if16.in_start = in_start;
    assign if1.inData  = din;  assign if1.in_start  = in_start;

    stage_stride_unpermutation #(.DATA_WIDTH_PER_INPUT(DW), .INPUT_PER_CYCLE(IPC), .N(1024), .STRIDE(2))
        u_s2 (.clk(clk), .rst(rst), .bus(if2.slave));
    stage_stride_unpermutation #(.DATA_WIDTH_PER_INPUT(DW), .INPUT_PER_CYCLE(IPC), .N(1024), .STRIDE(16))
        u_s16 (.clk(clk), .rst(rst), .bus(if16.slave));
    stage_stride_unpermutation #(.DATA_WIDTH_PER_INPUT(DW), .INPUT_PER_CYCLE(IPC), .N(1024), .STRIDE(1))
        u_s1 (.clk(clk), .rst(rst), .bus(if1.slave));

    // Per-cycle output log, captured mid-cycle on the falling edge.
    logic [DW-1:0] lg2 [W][IPC];
    logic [DW-1:0] lg16[W][IPC];
    logic [DW-1:0] lg1 [W][IPC];
    logic          st2 [W];
    logic          st16[W];
    logic          st1 [W];
    int widx;

    always @(negedge clk) begin
        if (cyc >= org && cyc - org < W) begin
            widx = cyc - org;
            st2[widx]  = if2.out_start;
            st16[widx] = if16.out_start;
            st1[widx]  = if1.out_start;
            for (int l = 0; l < IPC; l++) begin
                lg2[widx][l]  = if2.outData[l];
                lg16[widx][l] = if16.outData[l];
                lg1[widx][l]  = if1.outData[l];
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Stimulus frames (start, base value, beats driven) and frames expected at the output.
    int sf_t[$], sf_b[$], sf_len[$];
    int ef_t[$], ef_b[$];
    int extra_c, rst_lo, rst_hi;

    task automatic chk(input string tag, input int c, input int l,
                       input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d lane=%0d: observed %0d expected %0d", tag, c, l, obs, exp);
        end
    endtask

    task automatic to_cycle(input int c);
        while (cyc < org + c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        in_start = 1'b0;
        for (int l = 0; l < IPC; l++) din[l] = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        org = cyc;
        sf_t.delete(); sf_b.delete(); sf_len.delete();
        ef_t.delete(); ef_b.delete();
        extra_c = -1; rst_lo = -1; rst_hi = -1;
    endtask

    task automatic drive(input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            to_cycle(c);
            in_start = 1'b0;
            for (int l = 0; l < IPC; l++) din[l] = '0;
            foreach (sf_t[f]) begin
                if (c >= sf_t[f] && c < sf_t[f] + sf_len[f]) begin
                    if (c == sf_t[f]) in_start = 1'b1;
                    for (int l = 0; l < IPC; l++)
                        din[l] = DW'(sf_b[f] + (c - sf_t[f]) * IPC + l);
                end
            end
            if (c == extra_c) in_start = 1'b1;
            rst = (c >= rst_lo && c < rst_hi);
        end
        to_cycle(ncyc);
        in_start = 1'b0;
        rst = 1'b0;
    endtask

    function automatic logic [31:0] exp_data(input int c, input int l, input int s_log2);
        foreach (ef_t[f]) begin
            int k = c - ef_t[f] - B - 1;
            if (k >= 0 && k < B)
                return 32'(ef_b[f]) + unperm_src_index(32'(k * IPC + l), 10, 32'(s_log2));
        end
        return 32'd0;
    endfunction

    function automatic logic [31:0] exp_start(input int c);
        foreach (ef_t[f]) if (c == ef_t[f] + B + 1) return 32'd1;
        return 32'd0;
    endfunction

    task automatic check_all(input string tag);
        for (int c = 0; c < W; c++) begin
            chk({tag, "_start_s2"},  c, 0, 32'(st2[c]),  exp_start(c));
            chk({tag, "_start_s16"}, c, 0, 32'(st16[c]), exp_start(c));
            chk({tag, "_start_s1"},  c, 0, 32'(st1[c]),  exp_start(c));
            for (int l = 0; l < IPC; l++) begin
                chk({tag, "_data_s2"},  c, l, 32'(lg2[c][l]),  exp_data(c, l, 1));
                chk({tag, "_data_s16"}, c, l, 32'(lg16[c][l]), exp_data(c, l, 4));
                chk({tag, "_data_s1"},  c, l, 32'(lg1[c][l]),  exp_data(c, l, 0));
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        in_start = 1'b0;
        for (int l = 0; l < IPC; l++) din[l] = '0;

        // Single frame, values 0..1023, in_start at cycle 3.
        reset_dut();
        chk("reset_start", 0, 0, 32'(if2.out_start), 32'd0);
        chk("reset_data",  0, 0, 32'(if2.outData[0]), 32'd0);
        sf_t.push_back(3); sf_b.push_back(0); sf_len.push_back(B);
        ef_t.push_back(3); ef_b.push_back(0);
        drive(W);
        check_all("single");
        // Hand-derived spot values.
        chk("s2_start_c20", 20, 0, 32'(st2[20]), 32'd1);
        chk("s2_start_c19", 19, 0, 32'(st2[19]), 32'd0);
        chk("s2_start_c21", 21, 0, 32'(st2[21]), 32'd0);
        for (int l = 0; l < IPC; l++) begin
            chk("s2_beat0",  20, l, 32'(lg2[20][l]),  32'(2 * l));
            chk("s2_beat8",  28, l, 32'(lg2[28][l]),  32'(2 * l + 1));
            chk("s16_beat0", 20, l, 32'(lg16[20][l]), 32'(16 * l));
            chk("s1_beat3",  23, l, 32'(lg1[23][l]),  32'(3 * IPC + l));
        end
        chk("s2_last",     35, 63, 32'(lg2[35][63]),  32'd1023);
        chk("s16_beat1_0", 21, 0,  32'(lg16[21][0]),  32'd1);
        chk("s2_after",    36, 0,  32'(lg2[36][0]),   32'd0);

        // Three back-to-back frames at spacing B.
        reset_dut();
        sf_t.push_back(3);  sf_b.push_back(0);    sf_len.push_back(B);
        sf_t.push_back(19); sf_b.push_back(1024); sf_len.push_back(B);
        sf_t.push_back(35); sf_b.push_back(2048); sf_len.push_back(B);
        ef_t.push_back(3);  ef_b.push_back(0);
        ef_t.push_back(19); ef_b.push_back(1024);
        ef_t.push_back(35); ef_b.push_back(2048);
        drive(W);
        check_all("b2b");
        chk("b2b_start36", 36, 0, 32'(st2[36]), 32'd1);
        chk("b2b_start52", 52, 0, 32'(st2[52]), 32'd1);
        chk("b2b_f2_beat0", 36, 5, 32'(lg2[36][5]), 32'd1034);
        chk("b2b_f3_last",  67, 63, 32'(lg2[67][63]), 32'd3071);

        // Extra in_start during FILL is ignored.
        reset_dut();
        sf_t.push_back(3); sf_b.push_back(0); sf_len.push_back(B);
        ef_t.push_back(3); ef_b.push_back(0);
        extra_c = 10;
        drive(W);
        check_all("extra");

        // Reset mid-FILL: aborted frame vanishes, new frame at 16.
        reset_dut();
        sf_t.push_back(3);  sf_b.push_back(0);    sf_len.push_back(9);
        sf_t.push_back(16); sf_b.push_back(5000); sf_len.push_back(B);
        ef_t.push_back(16); ef_b.push_back(5000);
        rst_lo = 12; rst_hi = 14;
        drive(W);
        check_all("midrst");
        chk("midrst_start33", 33, 0, 32'(st2[33]), 32'd1);
        chk("midrst_start20", 20, 0, 32'(st2[20]), 32'd0);
        chk("midrst_beat0",   33, 1, 32'(lg2[33][1]), 32'd5002);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
